// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: two-requester front end for a simple dual-port cache RAM.
// The read and write ports are arbitrated independently, each round-robin.
// A tag pipeline that is RD_LAT stages deep steers each read response back to
// the requester that issued it.
// Ports: Clk/Rst_n (async active-low); req{0,1}_{valid,we,addr,wdata,ready};
//        rsp{0,1}_{valid,rdata}; mem_{rdaddress,wraddress,data,wren,q} to RAM;
//        conflict_cnt = saturating count of cycles with a stalled request.
// Option: when `CACHE_ARB_BYPASS_EN is defined, a read and a write granted to the
//         same address in the same cycle return the new write data, not mem_q.
module cache_mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic [ADDR_W-1:0] mem_rdaddress,
    output logic [ADDR_W-1:0] mem_wraddress,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam int unsigned LAST = RD_LAT - 1;

    logic rd_prio;
    logic wr_prio;
    logic rd_cand0, rd_cand1, wr_cand0, wr_cand1;
    logic rd_gnt0, rd_gnt1, wr_gnt0, wr_gnt1;
    logic rd_any, wr_any;
    logic stall;
    logic [DATA_W-1:0] rsp_data;

    logic [RD_LAT-1:0] tag_vld;
    logic [RD_LAT-1:0] tag_id;

    // Grant logic: the prio pointer picks the winner only when both requesters contend
    always_comb begin
        rd_cand0 = req0_valid && !req0_we;
        rd_cand1 = req1_valid && !req1_we;
        wr_cand0 = req0_valid && req0_we;
        wr_cand1 = req1_valid && req1_we;
        rd_gnt0  = Rst_n && rd_cand0 && (!rd_cand1 || !rd_prio);
        rd_gnt1  = Rst_n && rd_cand1 && (!rd_cand0 || rd_prio);
        wr_gnt0  = Rst_n && wr_cand0 && (!wr_cand1 || !wr_prio);
        wr_gnt1  = Rst_n && wr_cand1 && (!wr_cand0 || wr_prio);
        rd_any   = rd_gnt0 || rd_gnt1;
        wr_any   = wr_gnt0 || wr_gnt1;
    end

    assign req0_ready = rd_gnt0 || wr_gnt0;
    assign req1_ready = rd_gnt1 || wr_gnt1;

    // RAM-side muxes; idle ports drive zeros
    always_comb begin
        mem_rdaddress = '0;
        mem_wraddress = '0;
        mem_data      = '0;
        mem_wren      = wr_any;
        if (rd_gnt0)      mem_rdaddress = req0_addr;
        else if (rd_gnt1) mem_rdaddress = req1_addr;
        if (wr_gnt0) begin
            mem_wraddress = req0_addr;
            mem_data      = req0_wdata;
        end else if (wr_gnt1) begin
            mem_wraddress = req1_addr;
            mem_data      = req1_wdata;
        end
    end

    // Priority pointers move to the loser after a contended cycle
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rd_prio <= 1'b0;
            wr_prio <= 1'b0;
        end else begin
            if (rd_cand0 && rd_cand1) rd_prio <= rd_gnt0;
            if (wr_cand0 && wr_cand1) wr_prio <= wr_gnt0;
        end
    end

    // Tag pipeline: stage 0 is loaded on the grant edge, so the last stage lines up with mem_q
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            tag_vld <= '0;
            tag_id  <= '0;
        end else begin
            tag_vld[0] <= rd_any;
            tag_id[0]  <= rd_gnt1;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
        end
    end

`ifdef CACHE_ARB_BYPASS_EN
    logic [RD_LAT-1:0] tag_byp;
    logic [DATA_W-1:0] tag_wdata [RD_LAT];
    logic              byp_hit;

    // A same-cycle write to the address being read wins over the stale RAM data
    assign byp_hit = rd_any && wr_any && (mem_rdaddress == mem_wraddress);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            tag_byp <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) tag_wdata[i] <= '0;
        end else begin
            tag_byp[0]   <= byp_hit;
            tag_wdata[0] <= mem_data;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                tag_byp[i]   <= tag_byp[i-1];
                tag_wdata[i] <= tag_wdata[i-1];
            end
        end
    end

    assign rsp_data = tag_byp[LAST] ? tag_wdata[LAST] : mem_q;
`else
    assign rsp_data = mem_q;
`endif

    assign rsp0_valid = tag_vld[LAST] && !tag_id[LAST];
    assign rsp1_valid = tag_vld[LAST] && tag_id[LAST];
    assign rsp0_rdata = rsp_data;
    assign rsp1_rdata = rsp_data;

    // Conflict counter: at most one requester can stall per cycle; it saturates instead of wrapping
    assign stall = (req0_valid && !req0_ready) || (req1_valid && !req1_ready);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            conflict_cnt <= '0;
        end else if (stall && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter.
// It drives two instances (RD_LAT=1 and RD_LAT=3) with identical stimulus.
// Each instance has its own RAM model: registered read, old data on read-during-write.
module tb_cache_mem_arbiter;

    localparam int unsigned CW = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic req0_valid, req0_we, req1_valid, req1_we;
    logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;

    logic d1_rdy0, d1_rdy1, d1_rsp0_v, d1_rsp1_v, d1_wren;
    logic [31:0] d1_rsp0_d, d1_rsp1_d, d1_rda, d1_wra, d1_wd, d1_q;
    logic [CW-1:0] d1_cnt;
    logic d3_rdy0, d3_rdy1, d3_rsp0_v, d3_rsp1_v, d3_wren;
    logic [31:0] d3_rsp0_d, d3_rsp1_d, d3_rda, d3_wra, d3_wd, d3_q;
    logic [CW-1:0] d3_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .CNT_W(CW)) u_dut1 (
        .Clk(clk), .Rst_n(rst_n),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(d1_rdy0),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(d1_rdy1),
        .rsp0_valid(d1_rsp0_v), .rsp0_rdata(d1_rsp0_d),
        .rsp1_valid(d1_rsp1_v), .rsp1_rdata(d1_rsp1_d),
        .mem_rdaddress(d1_rda), .mem_wraddress(d1_wra), .mem_data(d1_wd),
        .mem_wren(d1_wren), .mem_q(d1_q), .conflict_cnt(d1_cnt)
    );

    cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3), .CNT_W(CW)) u_dut3 (
        .Clk(clk), .Rst_n(rst_n),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(d3_rdy0),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(d3_rdy1),
        .rsp0_valid(d3_rsp0_v), .rsp0_rdata(d3_rsp0_d),
        .rsp1_valid(d3_rsp1_v), .rsp1_rdata(d3_rsp1_d),
        .mem_rdaddress(d3_rda), .mem_wraddress(d3_wra), .mem_data(d3_wd),
        .mem_wren(d3_wren), .mem_q(d3_q), .conflict_cnt(d3_cnt)
    );

    // RAM models: an unwritten location reads back as its low address byte repeated four times
    logic [31:0] ram1 [256];
    logic [31:0] ram3 [256];
    bit          wv1  [256] = '{default: 1'b0};
    bit          wv3  [256] = '{default: 1'b0};
    logic [31:0] q3a, q3b;

    always @(posedge clk) begin
        logic [7:0] ri, wi;
        ri = 8'(d1_rda);
        wi = 8'(d1_wra);
        d1_q <= wv1[ri] ? ram1[ri] : {4{ri}};
        if (d1_wren) begin
            ram1[wi] = d1_wd;
            wv1[wi]  = 1'b1;
        end
    end

    always @(posedge clk) begin
        logic [7:0] ri, wi;
        ri = 8'(d3_rda);
        wi = 8'(d3_wra);
        q3a  <= wv3[ri] ? ram3[ri] : {4{ri}};
        q3b  <= q3a;
        d3_q <= q3b;
        if (d3_wren) begin
            ram3[wi] = d3_wd;
            wv3[wi]  = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_req(input int n, input logic v, input logic we,
                           input logic [31:0] a, input logic [31:0] d);
        if (n == 0) begin
            req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
        end
    endtask

    task automatic idle();
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [6:0] e_rdy0, e_rdy1, e1_r0, e1_r1, e3_r0, e3_r1;
        logic [31:0] byp_exp;

        // Reset with every request valid
        rst_n = 1'b0;
        set_req(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        set_req(1, 1'b1, 1'b0, 32'h10, 32'h0);
        mid();
        chk("rst_rdy0", 32'(d1_rdy0), 32'h0);
        chk("rst_rdy1", 32'(d1_rdy1), 32'h0);
        chk("rst_rsp0_v", 32'(d1_rsp0_v), 32'h0);
        chk("rst_rsp1_v", 32'(d1_rsp1_v), 32'h0);
        chk("rst_wren", 32'(d1_wren), 32'h0);
        chk("rst_cnt", 32'(d1_cnt), 32'h0);
        tick();
        idle();
        rst_n = 1'b1;
        tick();

        // Write then read back through the other requester
        set_req(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        mid();
        chk("t2_wr_rdy0", 32'(d1_rdy0), 32'h1);
        chk("t2_wren", 32'(d1_wren), 32'h1);
        chk("t2_wraddr", d1_wra, 32'h10);
        tick();
        idle();
        set_req(1, 1'b1, 1'b0, 32'h10, 32'h0);
        mid();
        chk("t2_rd_rdy1", 32'(d1_rdy1), 32'h1);
        chk("t2_rdaddr", d1_rda, 32'h10);
        chk("t2_wren_off", 32'(d1_wren), 32'h0);
        tick();
        idle();
        mid();
        chk("t2_rsp1_v", 32'(d1_rsp1_v), 32'h1);
        chk("t2_rsp1_d", d1_rsp1_d, 32'hDEADBEEF);
        chk("t2_rsp0_v", 32'(d1_rsp0_v), 32'h0);
        tick();
        mid();
        chk("t2_rsp1_once", 32'(d1_rsp1_v), 32'h0);
        tick();

        // Contending reads: requester 0 first, then requester 1
        set_req(0, 1'b1, 1'b0, 32'h20, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'h24, 32'h0);
        mid();
        chk("t3_rdy0", 32'(d1_rdy0), 32'h1);
        chk("t3_rdy1", 32'(d1_rdy1), 32'h0);
        chk("t3_rdaddr0", d1_rda, 32'h20);
        tick();
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        mid();
        chk("t3_rdy1_next", 32'(d1_rdy1), 32'h1);
        chk("t3_rdaddr1", d1_rda, 32'h24);
        chk("t3_rsp0_v", 32'(d1_rsp0_v), 32'h1);
        chk("t3_rsp0_d", d1_rsp0_d, 32'h20202020);
        tick();
        idle();
        mid();
        chk("t3_rsp1_v", 32'(d1_rsp1_v), 32'h1);
        chk("t3_rsp1_d", d1_rsp1_d, 32'h24242424);
        chk("t3_rsp0_v_off", 32'(d1_rsp0_v), 32'h0);
        chk("t3_cnt", 32'(d1_cnt), 32'h1);
        tick();

        // Read granted, then reset: the in-flight read must be dropped
        set_req(0, 1'b1, 1'b0, 32'h20, 32'h0);
        mid();
        chk("t6_rd_rdy0", 32'(d1_rdy0), 32'h1);
        tick();
        rst_n = 1'b0;
        idle();
        mid();
        chk("t6_rst_d3_rsp0", 32'(d3_rsp0_v), 32'h0);
        chk("t6_rst_cnt", 32'(d1_cnt), 32'h0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("t6_d1_rsp0_dropped", 32'(d1_rsp0_v), 32'h0);
            chk("t6_d3_rsp0_dropped", 32'(d3_rsp0_v), 32'h0);
            tick();
        end

        // Both hold reads for 4 cycles: grants alternate, RD_LAT=3 responses follow 3 cycles after each grant
        e_rdy0 = 7'b0000101; e_rdy1 = 7'b0001010;
        e1_r0  = 7'b0001010; e1_r1  = 7'b0010100;
        e3_r0  = 7'b0101000; e3_r1  = 7'b1010000;
        for (int i = 0; i < 7; i++) begin
            if (i < 4) begin
                set_req(0, 1'b1, 1'b0, 32'h40, 32'h0);
                set_req(1, 1'b1, 1'b0, 32'h44, 32'h0);
            end else begin
                idle();
            end
            mid();
            chk("t4_rd_rdy0", 32'(d1_rdy0), 32'(e_rdy0[i]));
            chk("t4_rd_rdy1", 32'(d1_rdy1), 32'(e_rdy1[i]));
            chk("t4_d1_rsp0_v", 32'(d1_rsp0_v), 32'(e1_r0[i]));
            chk("t4_d1_rsp1_v", 32'(d1_rsp1_v), 32'(e1_r1[i]));
            chk("t4_d3_rsp0_v", 32'(d3_rsp0_v), 32'(e3_r0[i]));
            chk("t4_d3_rsp1_v", 32'(d3_rsp1_v), 32'(e3_r1[i]));
            if (e3_r0[i]) chk("t4_d3_rsp0_d", d3_rsp0_d, 32'h40404040);
            if (e3_r1[i]) chk("t4_d3_rsp1_d", d3_rsp1_d, 32'h44444444);
            if (e1_r1[i]) chk("t4_d1_rsp1_d", d1_rsp1_d, 32'h44444444);
            tick();
        end
        mid();
        chk("t4_rd_cnt", 32'(d1_cnt), 32'h4);
        tick();

        // Both hold writes for 4 cycles
        for (int i = 0; i < 4; i++) begin
            set_req(0, 1'b1, 1'b1, 32'h50, 32'h11111111);
            set_req(1, 1'b1, 1'b1, 32'h54, 32'h22222222);
            mid();
            chk("t4_wr_rdy0", 32'(d1_rdy0), (i % 2 == 0) ? 32'h1 : 32'h0);
            chk("t4_wr_rdy1", 32'(d1_rdy1), (i % 2 == 0) ? 32'h0 : 32'h1);
            chk("t4_wr_addr", d1_wra, (i % 2 == 0) ? 32'h50 : 32'h54);
            tick();
        end
        idle();
        mid();
        chk("t4_wr_cnt", 32'(d1_cnt), 32'h8);
        tick();

        // Read and write to the same address in the same cycle
        set_req(1, 1'b1, 1'b1, 32'h30, 32'hA5A5A5A5);
        tick();
        idle();
        tick();
`ifdef CACHE_ARB_BYPASS_EN
        byp_exp = 32'h12345678;
`else
        byp_exp = 32'hA5A5A5A5;
`endif
        set_req(0, 1'b1, 1'b1, 32'h30, 32'h12345678);
        set_req(1, 1'b1, 1'b0, 32'h30, 32'h0);
        mid();
        chk("t5_rdy0", 32'(d1_rdy0), 32'h1);
        chk("t5_rdy1", 32'(d1_rdy1), 32'h1);
        chk("t5_d3_rdy0", 32'(d3_rdy0), 32'h1);
        chk("t5_d3_rdy1", 32'(d3_rdy1), 32'h1);
        tick();
        idle();
        mid();
        chk("t5_d1_rsp1_v", 32'(d1_rsp1_v), 32'h1);
        chk("t5_d1_rsp1_d", d1_rsp1_d, byp_exp);
        chk("t5_d1_rsp0_v", 32'(d1_rsp0_v), 32'h0);
        tick();
        tick();
        mid();
        chk("t5_d3_rsp1_v", 32'(d3_rsp1_v), 32'h1);
        chk("t5_d3_rsp1_d", d3_rsp1_d, byp_exp);
        tick();
        set_req(0, 1'b1, 1'b0, 32'h30, 32'h0);
        tick();
        idle();
        mid();
        chk("t5_readback_v", 32'(d1_rsp0_v), 32'h1);
        chk("t5_readback_d", d1_rsp0_d, 32'h12345678);
        chk("t5_cnt", 32'(d1_cnt), 32'h8);
        tick();

        // Saturation: more than 2^CW stall cycles from a count of 8
        set_req(0, 1'b1, 1'b0, 32'h60, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'h64, 32'h0);
        repeat (260) tick();
        mid();
        chk("t6_sat_d1", 32'(d1_cnt), 32'hFF);
        chk("t6_sat_d3", 32'(d3_cnt), 32'hFF);
        tick();
        mid();
        chk("t6_sat_hold", 32'(d1_cnt), 32'hFF);
        tick();
        idle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
